// File: rtl/touch_key_gen_pkg.sv
// rtl/touch_key_gen_pkg.sv - shared state type, counter width and default timings
package touch_key_gen_pkg;

  localparam int CNT_W        = 24;
  localparam int HOLD_CYC_DEF = 5_000_000;
  localparam int GAP_CYC_DEF  = 2_500_000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/touch_key_gen_tap_timer.sv
// rtl/touch_key_gen_tap_timer.sv - 24-bit per-state cycle counter with terminal count
module tap_timer
  import touch_key_gen_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  assign o_tc = (r_cnt == i_limit - CNT_W'(1));

  // Saturates at the terminal count so it can never wrap inside a state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (!o_tc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/touch_key_gen.sv
// rtl/touch_key_gen.sv - emulates a burst of taps on a touch-sensor line
module touch_key_gen
  import touch_key_gen_pkg::*;
#(
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int GAP_CYC  = GAP_CYC_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       tap_req,
  input  logic [3:0] tap_num,
  output logic       touch_key,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYC);

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_taps;
  logic             r_touch_key;
  logic             r_busy;
  logic             r_done;
  logic             w_clear;
  logic             w_tc;
  logic [CNT_W-1:0] w_limit;

  assign w_limit = (r_state == ST_PRESS) ? HOLD_LIM : GAP_LIM;

  tap_timer u_tap_timer (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_clear (w_clear),
    .i_limit (w_limit),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (tap_req && (tap_num != 4'd0)) w_next = ST_PRESS;
      ST_PRESS:  if (w_tc) w_next = ST_GAP;
      ST_GAP:    if (w_tc) w_next = (r_taps == 4'd0) ? ST_FINISH : ST_PRESS;
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    w_clear = (w_next != r_state) || (r_state == ST_IDLE);
  end

  // Outputs trail the state by one edge, giving the one-cycle touch latency.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_taps      <= 4'd0;
      r_touch_key <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && (w_next == ST_PRESS)) begin
        r_taps <= tap_num;
      end else if ((r_state == ST_PRESS) && (w_next == ST_GAP) && (r_taps != 4'd0)) begin
        r_taps <= r_taps - 4'd1;
      end
      r_touch_key <= (r_state == ST_PRESS);
      r_busy      <= (r_state != ST_IDLE);
      r_done      <= (r_state == ST_FINISH);
    end
  end

  assign touch_key = r_touch_key;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
